// File: rtl/ram_responder_if.sv
// Shared RAM-side types plus the request/response bundle between the
// memory controller (master) and the RAM responder (slave).
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

interface ram_responder_if;
  cpu_types_pkg::word_t     ramaddr;
  cpu_types_pkg::word_t     ramstore;
  logic                     ramREN;
  logic                     ramWEN;
  cpu_types_pkg::word_t     ramload;
  cpu_types_pkg::ramstate_t ramstate;

  modport master (output ramaddr, ramstore, ramREN, ramWEN,
                  input  ramload, ramstate);
  modport slave  (input  ramaddr, ramstore, ramREN, ramWEN,
                  output ramload, ramstate);
endinterface

// File: rtl/ram_responder.sv
// Fixed-latency word RAM model answering ramREN/ramWEN with the
// FREE/BUSY/ACCESS/ERROR handshake, plus completed read/write counters.
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int LAT        = 2,
  parameter int DEPTH_BITS = 8
) (
  input  logic            CLK,
  input  logic            nRST,
  ram_responder_if.slave  ram,
  output word_t           rd_count,
  output word_t           wr_count
);

  localparam int         DEPTH  = 1 << DEPTH_BITS;
  localparam logic [3:0] RELOAD = 4'(LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACC, S_ERR} fsm_t;

  fsm_t                  state_reg;
  logic [3:0]            cnt_reg;
  logic [DEPTH_BITS-1:0] idx_reg;
  logic                  rd_op_reg;
  word_t                 mem [DEPTH];

  logic                  req;
  logic                  bad;
  logic                  changed;
  logic                  wr_en;
  logic [DEPTH_BITS-1:0] idx;

  assign req     = ram.ramREN | ram.ramWEN;
  assign bad     = (ram.ramREN & ram.ramWEN)
                 | (ram.ramaddr[1:0] != 2'b00)
                 | (ram.ramaddr[31:DEPTH_BITS+2] != '0);
  assign idx     = ram.ramaddr[DEPTH_BITS+1:2];
  assign changed = (idx != idx_reg) | (ram.ramREN != rd_op_reg);
  assign wr_en   = (state_reg == S_ACC) & ~rd_op_reg;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      rd_op_reg <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      case (state_reg)
        S_BUSY: begin
          if (!req) begin
            state_reg <= S_IDLE;
          end else if (bad) begin
            state_reg <= S_ERR;
          end else if (changed) begin
            idx_reg   <= idx;
            rd_op_reg <= ram.ramREN;
            cnt_reg   <= RELOAD;
          end else if (cnt_reg == 4'd0) begin
            state_reg <= S_ACC;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: begin
          // IDLE, ACC and ERR share the same exit rule; a held request
          // after ACC always opens a fresh transaction.
          if (state_reg == S_ACC) begin
            if (rd_op_reg) rd_count <= rd_count + 32'd1;
            else           wr_count <= wr_count + 32'd1;
          end
          if (!req) begin
            state_reg <= S_IDLE;
          end else if (bad) begin
            state_reg <= S_ERR;
          end else begin
            state_reg <= S_BUSY;
            idx_reg   <= idx;
            rd_op_reg <= ram.ramREN;
            cnt_reg   <= RELOAD;
          end
        end
      endcase
    end
  end

  // One register per word so nRST can clear the whole array asynchronously.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)                                     mem[gi] <= '0;
      else if (wr_en && idx_reg == DEPTH_BITS'(gi))  mem[gi] <= ram.ramstore;
    end
  end

  always_comb begin
    ram.ramload = '0;
    if (state_reg == S_ACC && rd_op_reg) ram.ramload = mem[idx_reg];
  end

  always_comb begin
    case (state_reg)
      S_BUSY:  ram.ramstate = BUSY;
      S_ACC:   ram.ramstate = ACCESS;
      S_ERR:   ram.ramstate = ERROR;
      default: ram.ramstate = FREE;
    endcase
  end

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: directed cycle tables on a LAT=2 and a LAT=1
// instance, plus random traffic against a deadline-based reference model.
module tb_ram_responder;
  import cpu_types_pkg::*;

  localparam int I = 0, R = 1, W = 2, RW = 3;

  logic  CLK   = 1'b0;
  logic  nRST  = 1'b1;
  logic  t_ren = 1'b0;
  logic  t_wen = 1'b0;
  word_t t_addr  = '0;
  word_t t_store = '0;
  word_t rd_a, wr_a, rd_b, wr_b;

  ram_responder_if ifa ();
  ram_responder_if ifb ();

  assign ifa.ramREN   = t_ren;
  assign ifa.ramWEN   = t_wen;
  assign ifa.ramaddr  = t_addr;
  assign ifa.ramstore = t_store;
  assign ifb.ramREN   = t_ren;
  assign ifb.ramWEN   = t_wen;
  assign ifb.ramaddr  = t_addr;
  assign ifb.ramstore = t_store;

  ram_responder #(.LAT(2), .DEPTH_BITS(8)) dut_a (
    .CLK(CLK), .nRST(nRST), .ram(ifa), .rd_count(rd_a), .wr_count(wr_a));
  ram_responder #(.LAT(1), .DEPTH_BITS(6)) dut_b (
    .CLK(CLK), .nRST(nRST), .ram(ifb), .rd_count(rd_b), .wr_count(wr_b));

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic ramstate_t st_of(input int d);
    return (d == 0) ? ifa.ramstate : ifb.ramstate;
  endfunction
  function automatic word_t load_of(input int d);
    return (d == 0) ? ifa.ramload : ifb.ramload;
  endfunction
  function automatic word_t rdc_of(input int d);
    return (d == 0) ? rd_a : rd_b;
  endfunction
  function automatic word_t wrc_of(input int d);
    return (d == 0) ? wr_a : wr_b;
  endfunction
  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction
  function automatic int depth_of(input int d);
    return (d == 0) ? 8 : 6;
  endfunction

  task automatic drive(input int op, input word_t addr, input word_t store);
    t_ren   = (op == R || op == RW);
    t_wen   = (op == W || op == RW);
    t_addr  = addr;
    t_store = store;
  endtask

  // ---------------- directed cycle tables ----------------
  typedef struct {
    int        op;
    word_t     addr;
    word_t     store;
    ramstate_t st;
    word_t     load;
  } vec_t;
  vec_t vq[$];

  function automatic void v(input int op, input word_t addr, input word_t store,
                            input ramstate_t st, input word_t load);
    vec_t e;
    e.op = op; e.addr = addr; e.store = store; e.st = st; e.load = load;
    vq.push_back(e);
  endfunction

  task automatic run_table(input int d, input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].op, vq[i].addr, vq[i].store);
      @(negedge CLK);
      check($sformatf("%s[%0d].state", tag, i), 32'(st_of(d)), 32'(vq[i].st));
      check($sformatf("%s[%0d].load", tag, i), load_of(d), vq[i].load);
      if (vq[i].st == ACCESS)
        $display("%s dut%0d op=%0d addr=%08h load=%08h rd=%0d wr=%0d",
                 tag, d, vq[i].op, vq[i].addr, load_of(d), rdc_of(d), wrc_of(d));
      @(posedge CLK); #1;
    end
    vq.delete();
  endtask

  // ---------------- reference model ----------------
  // Transaction view: a request accepted in cycle c reaches ACCESS in
  // cycle c+LAT+1 unless dropped, made bad, or replaced before then.
  int    cyc;
  int    m_dl   [2];
  bit    m_err  [2];
  word_t m_addr [2];
  bit    m_rd   [2];
  word_t m_mem  [2][256];
  word_t m_rdc  [2];
  word_t m_wrc  [2];

  task automatic model_reset();
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      m_dl[d] = -1; m_err[d] = 0; m_addr[d] = '0; m_rd[d] = 0;
      m_rdc[d] = '0; m_wrc[d] = '0;
      for (int k = 0; k < 256; k++) m_mem[d][k] = '0;
    end
  endtask

  function automatic ramstate_t m_state(input int d);
    if (m_err[d])       return ERROR;
    if (m_dl[d] == cyc) return ACCESS;
    if (m_dl[d] > cyc)  return BUSY;
    return FREE;
  endfunction

  function automatic bit m_bad(input int d);
    return (t_ren && t_wen) || (t_addr[1:0] != 2'b00) ||
           ((t_addr >> (depth_of(d) + 2)) != 0);
  endfunction

  task automatic model_cycle(input int d);
    ramstate_t st = m_state(d);
    word_t     exp_load = '0;
    if (st == ACCESS && m_rd[d]) exp_load = m_mem[d][m_addr[d] >> 2];
    check($sformatf("rand dut%0d c%0d state", d, cyc), 32'(st_of(d)), 32'(st));
    check($sformatf("rand dut%0d c%0d load", d, cyc), load_of(d), exp_load);
    check($sformatf("rand dut%0d c%0d rd_count", d, cyc), rdc_of(d), m_rdc[d]);
    check($sformatf("rand dut%0d c%0d wr_count", d, cyc), wrc_of(d), m_wrc[d]);
    if (st == ACCESS) begin
      if (m_rd[d]) m_rdc[d] = m_rdc[d] + 1;
      else begin
        m_mem[d][m_addr[d] >> 2] = t_store;
        m_wrc[d] = m_wrc[d] + 1;
      end
    end
    if (!(t_ren || t_wen)) begin
      m_dl[d] = -1; m_err[d] = 0;
    end else if (m_bad(d)) begin
      m_dl[d] = -1; m_err[d] = 1;
    end else begin
      m_err[d] = 0;
      if (st != BUSY || t_addr != m_addr[d] || t_ren != m_rd[d]) begin
        m_dl[d]   = cyc + lat_of(d) + 1;
        m_addr[d] = t_addr;
        m_rd[d]   = t_ren;
      end
    end
  endtask

  task automatic rand_inputs();
    int r = $urandom_range(0, 99);
    if (r < 68) begin
      // hold current request
    end else if (r < 80) begin
      t_ren   = 1'($urandom_range(0, 1));
      t_wen   = ~t_ren;
      t_addr  = 32'($urandom_range(0, 127)) << 2;
      t_store = $urandom;
    end else if (r < 88) begin
      t_ren = 1'b0; t_wen = 1'b0;
    end else if (r < 91) begin
      t_ren = 1'b1; t_wen = 1'b1;
    end else if (r < 94) begin
      t_addr = (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(1, 3));
      if (!t_ren && !t_wen) t_ren = 1'b1;
    end else if (r < 96) begin
      t_addr = 32'h400 | (32'($urandom_range(0, 255)) << 2);
      if (!t_ren && !t_wen) t_wen = 1'b1;
    end else begin
      t_store = $urandom;
    end
  endtask

  task automatic pulse_reset();
    drive(I, '0, '0);
    @(negedge CLK); #2 nRST = 1'b0;
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    word_t rb0, wb0;

    // Reset state, observed while nRST is still asserted
    #2 nRST = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset dut%0d state", d), 32'(st_of(d)), 32'(FREE));
      check($sformatf("reset dut%0d load", d), load_of(d), '0);
      check($sformatf("reset dut%0d rd_count", d), rdc_of(d), '0);
      check($sformatf("reset dut%0d wr_count", d), wrc_of(d), '0);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;

    // LAT=2: write/read, mid-BUSY change, abort, errors, block fill
    v(W, 32'h10, 32'hDEADBEEF, FREE, 0);  v(W, 32'h10, 32'hDEADBEEF, BUSY, 0);
    v(W, 32'h10, 32'hDEADBEEF, BUSY, 0);  v(W, 32'h10, 32'hDEADBEEF, ACCESS, 0);
    v(R, 32'h10, 0, BUSY, 0);   v(R, 32'h10, 0, BUSY, 0);
    v(R, 32'h10, 0, BUSY, 0);   v(R, 32'h10, 0, ACCESS, 32'hDEADBEEF);
    v(I, 0, 0, BUSY, 0);        v(I, 0, 0, FREE, 0);
    v(R, 32'h20, 0, FREE, 0);   v(R, 32'h24, 0, BUSY, 0);
    v(R, 32'h24, 0, BUSY, 0);   v(R, 32'h24, 0, BUSY, 0);
    v(R, 32'h24, 0, ACCESS, 0); v(I, 0, 0, BUSY, 0);      v(I, 0, 0, FREE, 0);
    v(W, 32'h30, 32'h1234, FREE, 0); v(W, 32'h30, 32'h1234, BUSY, 0);
    v(I, 0, 0, BUSY, 0);        v(I, 0, 0, FREE, 0);
    v(R, 32'h30, 0, FREE, 0);   v(R, 32'h30, 0, BUSY, 0);
    v(R, 32'h30, 0, BUSY, 0);   v(R, 32'h30, 0, ACCESS, 0);
    v(I, 0, 0, BUSY, 0);        v(I, 0, 0, FREE, 0);
    v(RW, 32'h10, 32'h99, FREE, 0);  v(RW, 32'h10, 32'h99, ERROR, 0);
    v(RW, 32'h10, 32'h99, ERROR, 0); v(I, 0, 0, ERROR, 0); v(I, 0, 0, FREE, 0);
    v(R, 32'h2, 0, FREE, 0);    v(R, 32'h2, 0, ERROR, 0);
    v(I, 0, 0, ERROR, 0);       v(I, 0, 0, FREE, 0);
    v(W, 32'h400, 32'h55, FREE, 0);  v(W, 32'h400, 32'h55, ERROR, 0);
    v(I, 0, 0, ERROR, 0);       v(I, 0, 0, FREE, 0);
    v(W, 32'h40, 32'hA1, FREE, 0);   v(W, 32'h40, 32'hA1, BUSY, 0);
    v(W, 32'h40, 32'hA1, BUSY, 0);   v(W, 32'h40, 32'hA1, ACCESS, 0);
    v(W, 32'h44, 32'hB2, BUSY, 0);   v(W, 32'h44, 32'hB2, BUSY, 0);
    v(W, 32'h44, 32'hB2, BUSY, 0);   v(W, 32'h44, 32'hB2, ACCESS, 0);
    v(I, 0, 0, BUSY, 0);        v(I, 0, 0, FREE, 0);
    v(R, 32'h40, 0, FREE, 0);   v(R, 32'h40, 0, BUSY, 0);
    v(R, 32'h40, 0, BUSY, 0);   v(R, 32'h40, 0, ACCESS, 32'hA1);
    v(R, 32'h44, 0, BUSY, 0);   v(R, 32'h44, 0, BUSY, 0);
    v(R, 32'h44, 0, BUSY, 0);   v(R, 32'h44, 0, ACCESS, 32'hB2);
    v(I, 0, 0, BUSY, 0);        v(I, 0, 0, FREE, 0);
    v(R, 32'h10, 0, FREE, 0);   v(R, 32'h10, 0, BUSY, 0);
    v(R, 32'h10, 0, BUSY, 0);   v(R, 32'h10, 0, ACCESS, 32'hDEADBEEF);
    v(I, 0, 0, BUSY, 0);        v(I, 0, 0, FREE, 0);
    run_table(0, "lat2");
    check("lat2 rd_count", rd_a, 32'd6);
    check("lat2 wr_count", wr_a, 32'd3);

    // LAT=1 sweep on the second instance, plus its own depth boundary
    rb0 = rd_b; wb0 = wr_b;
    for (int k = 0; k < 4; k++) begin
      word_t a = 32'(k) << 3;
      word_t dv = 32'hC0DE_0000 + 32'(k);
      v(W, a, dv, FREE, 0); v(W, a, dv, BUSY, 0); v(W, a, dv, ACCESS, 0);
      v(I, 0, 0, BUSY, 0);  v(I, 0, 0, FREE, 0);
      v(R, a, 0, FREE, 0);  v(R, a, 0, BUSY, 0);  v(R, a, 0, ACCESS, dv);
      v(I, 0, 0, BUSY, 0);  v(I, 0, 0, FREE, 0);
    end
    v(R, 32'h100, 0, FREE, 0); v(R, 32'h100, 0, ERROR, 0);
    v(I, 0, 0, ERROR, 0);      v(I, 0, 0, FREE, 0);
    run_table(1, "lat1");
    check("lat1 rd delta", rd_b - rb0, 32'd4);
    check("lat1 wr delta", wr_b - wb0, 32'd4);

    // Asynchronous reset in the middle of a write's BUSY phase
    drive(W, 32'h50, 32'hAA);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("rstmid pre state", 32'(ifa.ramstate), 32'(BUSY));
    #2 nRST = 1'b0;
    #1;
    check("rstmid state", 32'(ifa.ramstate), 32'(FREE));
    check("rstmid load", ifa.ramload, '0);
    check("rstmid rd_count", rd_a, '0);
    check("rstmid wr_count", wr_a, '0);
    drive(I, '0, '0);
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;
    v(R, 32'h50, 0, FREE, 0); v(R, 32'h50, 0, BUSY, 0);
    v(R, 32'h50, 0, BUSY, 0); v(R, 32'h50, 0, ACCESS, 0);
    v(I, 0, 0, BUSY, 0);      v(I, 0, 0, FREE, 0);
    v(R, 32'h10, 0, FREE, 0); v(R, 32'h10, 0, BUSY, 0);
    v(R, 32'h10, 0, BUSY, 0); v(R, 32'h10, 0, ACCESS, 0);
    v(I, 0, 0, BUSY, 0);      v(I, 0, 0, FREE, 0);
    run_table(0, "postrst");
    check("postrst rd_count", rd_a, 32'd2);
    check("postrst wr_count", wr_a, 32'd0);

    // Random traffic on both instances against the reference model
    pulse_reset();
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      rand_inputs();
      @(negedge CLK);
      model_cycle(0);
      model_cycle(1);
      cyc++;
      @(posedge CLK); #1;
    end
    $display("random phase: dut0 rd=%0d wr=%0d, dut1 rd=%0d wr=%0d",
             m_rdc[0], m_wrc[0], m_rdc[1], m_wrc[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
